// File: rtl/gcd_pkg.sv
// gcd_pkg: types and constants shared by the GCD feeder and the hgcd-side benches.
//   GCD_W       operand width of hgcd a/b/q
//   GCD_MAX_OUT jobs hgcd can hold at once (two engines)
//   gcd_pair_t  packed operand pair {a, b}
package gcd_pkg;
  localparam int GCD_W       = 8;
  localparam int GCD_MAX_OUT = 2;

  typedef struct packed {
    logic [GCD_W-1:0] a;
    logic [GCD_W-1:0] b;
  } gcd_pair_t;
endpackage

// File: rtl/gcd_feeder_fifo.sv
// gcd_feeder_fifo: synchronous FIFO, DEPTH x DW, head visible combinationally.
// Ports:
//   clk, reset      clock, async active-low reset (clears storage and pointers)
//   i_push, i_data  write strobe and data (ignored when full)
//   i_pop           read strobe (ignored when empty)
//   o_head          entry at the read pointer, always driven
//   o_full, o_empty, o_count  occupancy from registered state
module gcd_feeder_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic [DW-1:0]              i_data,
  input  logic                       i_pop,
  output logic [DW-1:0]              o_head,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  // Storage is cleared too, so the head reads zero straight out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/gcd_feeder.sv
// gcd_feeder: buffers operand pairs from a valid/ready producer and issues them
// to the dual-engine hgcd as single-cycle ld pulses, never exceeding the two
// jobs hgcd can hold and never issuing while hgcd is in write-back.
// Ports:
//   clk, reset             clock, async active-low reset
//   in_a, in_b, in_valid   producer pair;  in_ready = FIFO not full
//   gcd_a, gcd_b, gcd_ld   operands (FIFO head) and load strobe to hgcd
//   gcd_rdy                one pulse per job completed by hgcd
//   outstanding            jobs inside hgcd (0..2)
//   busy                   FIFO non-empty or jobs outstanding
//   err                    sticky: rdy seen with nothing outstanding
// Optional (macro GCD_FEEDER_STATS_EN): stat_issued / stat_done, 16-bit
// wrapping counts of ld and rdy pulses.
module gcd_feeder
  import gcd_pkg::*;
#(
  parameter int W       = GCD_W,
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = GCD_MAX_OUT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] gcd_a,
  output logic [W-1:0] gcd_b,
  output logic         gcd_ld,
  input  logic         gcd_rdy,
  output logic [1:0]   outstanding,
  output logic         busy,
  output logic         err
`ifdef GCD_FEEDER_STATS_EN
  ,
  output logic [15:0]  stat_issued,
  output logic [15:0]  stat_done
`endif
);
  logic [2*W-1:0]          w_head;
  logic                    w_full;
  logic                    w_empty;
  logic [$clog2(DEPTH):0]  w_count;
  logic                    w_push;
  logic                    w_issue;
  logic [1:0]              r_outstanding;
  logic                    r_hold;
  logic                    r_err;

  gcd_feeder_fifo #(.DW(2*W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  ({in_a, in_b}),
    .i_pop   (w_issue),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Held low during reset so the producer never sees a ready FIFO it cannot use.
  assign in_ready = reset & ~w_full;
  assign w_push   = in_valid & in_ready;

  // Registered state only: hgcd.rdy depends combinationally on hgcd.ld, so
  // letting gcd_rdy reach gcd_ld would close a loop through hgcd.
  assign w_issue = ~w_empty & (r_outstanding < 2'(MAX_OUT)) & ~r_hold;

  assign gcd_ld      = w_issue;
  assign gcd_a       = w_head[2*W-1:W];
  assign gcd_b       = w_head[W-1:0];
  assign outstanding = r_outstanding;
  assign busy        = (w_count != '0) | (r_outstanding != 2'd0);
  assign err         = r_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_outstanding <= 2'd0;
      r_hold        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      // A completion with both engines busy may be followed by hgcd's
      // write-back cycle, where a second rdy can arrive and ld is dropped.
      r_hold <= gcd_rdy & (r_outstanding == 2'(MAX_OUT));
      case ({w_issue, gcd_rdy})
        2'b10: r_outstanding <= r_outstanding + 2'd1;
        2'b01: begin
          if (r_outstanding == 2'd0) r_err <= 1'b1;
          else                       r_outstanding <= r_outstanding - 2'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef GCD_FEEDER_STATS_EN
  logic [15:0] r_stat_issued;
  logic [15:0] r_stat_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stat_issued <= 16'd0;
      r_stat_done   <= 16'd0;
    end else begin
      if (w_issue) r_stat_issued <= r_stat_issued + 16'd1;
      if (gcd_rdy) r_stat_done   <= r_stat_done + 16'd1;
    end
  end

  assign stat_issued = r_stat_issued;
  assign stat_done   = r_stat_done;
`endif
endmodule

// File: doc/gcd_feeder.md
Name: gcd_feeder

Overview:
- Upstream stage of the dual-engine GCD unit (hgcd). Buffers operand pairs from a valid/ready producer in a small FIFO and issues them to hgcd as single-cycle `ld` pulses.
- hgcd accepts at most 2 jobs in flight and has no backpressure, so this block tracks outstanding jobs through hgcd's `rdy` pulses. It never issues a `ld` that hgcd would drop: hgcd ignores `ld` in its both-busy and write-back states.

Parameters:
- W, 8, operand width (matches hgcd a/b/q width).
- DEPTH, 4, FIFO entries; power of two, >= 2.
- MAX_OUT, 2, maximum jobs in flight inside hgcd. Fixed by hgcd; do not change.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; assertion clears all state immediately.
- in_a  in  W  operand a from producer.
- in_b  in  W  operand b from producer.
- in_valid  in  1  producer has a pair on in_a/in_b.
- in_ready  out  1  FIFO can accept a pair.
- gcd_a  out  W  operand a to hgcd.a.
- gcd_b  out  W  operand b to hgcd.b.
- gcd_ld  out  1  one-cycle load strobe to hgcd.ld.
- gcd_rdy  in  1  hgcd.rdy; one pulse per completed job.
- outstanding  out  2  jobs currently inside hgcd (0..2).
- busy  out  1  FIFO non-empty or outstanding != 0.
- err  out  1  sticky protocol error flag.

Behaviour:
- Reset values: in_ready=0 while reset is asserted, then 1. gcd_ld=0, gcd_a=gcd_b=0 (FIFO head cleared), outstanding=0, busy=0, err=0, hold=0, FIFO empty.
- Reset mid-operation flushes the FIFO and outstanding count. The system must reset hgcd in the same cycle; results in flight are lost.
- Push: occurs when in_valid & in_ready. in_ready = !full, derived from registered count only. No push occurs when full, even if a pop happens in the same cycle. Simultaneous push and pop when neither full nor empty keeps the count unchanged.
- Issue condition: issue = !empty & (outstanding < MAX_OUT) & !hold.
  - It uses registered state only. gcd_ld must have no combinational path from gcd_rdy, because hgcd.rdy depends combinationally on hgcd.ld.
  - gcd_ld = issue. gcd_a/gcd_b = FIFO head, always driven.
  - Issue pops the FIFO head in the same cycle.
- Minimum latency: a pair accepted into an empty FIFO at edge N produces gcd_ld during cycle N+1.
- Outstanding update: next = outstanding + gcd_ld - gcd_rdy.
- gcd_rdy while outstanding==0 and !gcd_ld:
  - count stays at 0 (saturates);
  - err sets and stays set until reset.
- Hold flag:
  - Sets for exactly the next cycle when gcd_rdy=1 and outstanding==2.
  - Covers hgcd's write-back state, in which hgcd emits a second rdy and ignores ld.
  - Costs one idle cycle in the single-completion case; this is accepted.
- Back-to-back issue: allowed on consecutive cycles while outstanding < 2.
- gcd_ld and gcd_rdy may both be high in one cycle (hgcd paths S01/S10 with ld & rdy): net count change is 0.
- busy is combinational from registered state.

Optional Feature:
- Macro: GCD_FEEDER_STATS_EN.
- Defined:
  - Adds outputs stat_issued[15:0] and stat_done[15:0].
  - stat_issued increments on gcd_ld; stat_done increments on gcd_rdy.
  - Both wrap at 16'hFFFF -> 0 and reset to 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package gcd_pkg holds:
  - GCD_W=8 and GCD_MAX_OUT=2;
  - an operand-pair packed type {a,b} of 2*W bits, reused by hgcd-side benches.
- One sub-module: gcd_feeder_fifo. It is a synchronous FIFO, DEPTH x 2W, with push/pop/full/empty/count, head visible combinationally, and the same clk/reset.
- Issue control, outstanding counter, hold and err stay in the top.

Test Plan:
- Single job: push (12,18) into an empty FIFO.
  - Expect gcd_ld=1 for exactly one cycle on the next cycle, with gcd_a=12, gcd_b=18, then outstanding=1.
  - Drive rdy -> outstanding=0, busy=0.
- Three jobs back-to-back, (12,18), (35,21), (9,6), hgcd model slow.
  - Expect ld for jobs 1 and 2 in consecutive cycles, outstanding=2, no third ld.
  - After one rdy: one idle (hold) cycle, then ld with (9,6).
- Double completion: outstanding=2, model pulses rdy in 2 consecutive cycles (write-back path).
  - Expect no ld in the second rdy cycle; outstanding 2->1->0; err=0.
- Full FIFO: hgcd model never completes.
  - Push 2+DEPTH=6 pairs; in_ready=0 after the sixth.
  - A seventh valid is not accepted.
  - After one rdy plus the hold cycle, one pop occurs and in_ready returns to 1.
- Error and reset:
  - rdy with outstanding=0 -> err=1 and stays set.
  - Assert reset mid-traffic with FIFO=3 -> all outputs return to reset values asynchronously; err=0.
- GCD_FEEDER_STATS_EN: run 5 jobs to completion -> stat_issued=5, stat_done=5.
